// File: rtl/rng_seq_pkg.sv
// rng_seq_pkg: shared state encoding, default feedback mask and zero-seed fallback
package rng_seq_pkg;
  typedef enum logic [1:0] {EMPTY, READY, FULL} state_e;
  localparam logic [31:0] DEF_TAPS = 32'h8020_0003;
  localparam int ZERO_SEED = 1;
endpackage

// File: rtl/rng_lfsr.sv
// rng_lfsr: combinational Galois LFSR step with optional mix-in
//   s_i   : current LFSR state
//   mix_i : value XORed into the state before stepping (zero when unused)
//   nxt_o : next LFSR state
// A zero mixed state is forced to the fallback seed so the LFSR never locks up.
module rng_lfsr
  import rng_seq_pkg::*;
#(
  parameter int W = 32,
  parameter logic [W-1:0] TAPS = W'(DEF_TAPS)
) (
  input  logic [W-1:0] s_i,
  input  logic [W-1:0] mix_i,
  output logic [W-1:0] nxt_o
);
  logic [W-1:0] m;
  always_comb begin
    m = s_i ^ mix_i;
    m = (m == '0) ? W'(ZERO_SEED) : m;
    nxt_o = m[0] ? ((m >> 1) ^ TAPS) : (m >> 1);
  end
endmodule

// File: rtl/rng_seq_register.sv
// rng_seq_register: seeded LFSR symbol-sequence store with indexed read port
//   clk        : clock, all state on rising edge
//   reset      : asynchronous active-low reset
//   start_game : level; rising edge seeds the LFSR from rng_in and clears the sequence
//   rng_in     : free-running entropy source
//   append     : pulse; appends one LFSR-derived symbol
//   rd_req/rd_idx -> rd_valid/rd_sym/rd_err one cycle later
//   seeded, seq_len, seq_full : status
// Optional macro RNG_SEQ_RESEED_EN: mix rng_in into the LFSR on every accepted append.
module rng_seq_register
  import rng_seq_pkg::*;
#(
  parameter int SEED_W = 32,
  parameter int SYM_W = 2,
  parameter int DEPTH = 32,
  parameter logic [SEED_W-1:0] TAPS = SEED_W'(DEF_TAPS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_game,
  input  logic [SEED_W-1:0]          rng_in,
  input  logic                       append,
  input  logic                       rd_req,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic                       seeded,
  output logic [$clog2(DEPTH+1)-1:0] seq_len,
  output logic                       seq_full,
  output logic                       rd_valid,
  output logic [SYM_W-1:0]           rd_sym,
  output logic                       rd_err
);
  localparam int IW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  state_e            state_q, state_d;
  logic [SEED_W-1:0] lfsr_q, lfsr_d, lfsr_nxt, mix;
  logic [LW-1:0]     len_q, len_d, len_inc;
  logic              start_q, start_edge, acc, hit;
  logic              rd_valid_q, rd_valid_d, rd_err_q, rd_err_d;
  logic [SYM_W-1:0]  rd_sym_q, rd_sym_d;
  logic [SYM_W-1:0]  mem_q [DEPTH];
`ifdef RNG_SEQ_RESEED_EN
  assign mix = rng_in;
`else
  assign mix = '0;
`endif
  rng_lfsr #(.W(SEED_W), .TAPS(TAPS)) u_lfsr (.s_i(lfsr_q), .mix_i(mix), .nxt_o(lfsr_nxt));
  // Start edge wins over a coincident append.
  assign start_edge = start_game & ~start_q;
  assign acc = append & (state_q == READY) & ~start_edge;
  assign len_inc = len_q + 1'b1;
  // Read hit is judged against the pre-append length.
  assign hit = LW'(rd_idx) < len_q;
  always_comb begin
    state_d = start_edge ? READY : acc ? ((len_inc == LW'(DEPTH)) ? FULL : READY) : state_q;
    lfsr_d = start_edge ? ((rng_in == '0) ? SEED_W'(ZERO_SEED) : rng_in) : acc ? lfsr_nxt : lfsr_q;
    len_d = start_edge ? '0 : acc ? len_inc : len_q;
    rd_valid_d = rd_req;
    rd_sym_d = rd_req ? (hit ? mem_q[rd_idx] : '0) : rd_sym_q;
    rd_err_d = rd_req ? ~hit : rd_err_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      lfsr_q <= SEED_W'(ZERO_SEED);
      len_q <= '0;
      start_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_sym_q <= '0;
      rd_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      len_q <= len_d;
      start_q <= start_game;
      rd_valid_q <= rd_valid_d;
      rd_sym_q <= rd_sym_d;
      rd_err_q <= rd_err_d;
    end
  end
  // Storage is not reset; reads are gated by len_q.
  always_ff @(posedge clk) begin
    if (acc) mem_q[len_q[IW-1:0]] <= lfsr_nxt[SYM_W-1:0];
  end
  assign seeded = state_q != EMPTY;
  assign seq_full = state_q == FULL;
  assign seq_len = len_q;
  assign rd_valid = rd_valid_q;
  assign rd_sym = rd_sym_q;
  assign rd_err = rd_err_q;
endmodule

// File: tb/tb_rng_seq_register.sv
// tb_rng_seq_register: directed self-checking bench for rng_seq_register (default and DEPTH=4)
module tb_rng_seq_register;
  logic        clk = 0, reset, start_game, append, rd_req;
  logic [31:0] rng_in;
  logic [4:0]  rd_idx;
  logic        seeded, seq_full, rd_valid, rd_err;
  logic [5:0]  seq_len;
  logic [1:0]  rd_sym;
  logic        seeded4, seq_full4, rd_valid4, rd_err4;
  logic [2:0]  seq_len4;
  logic [1:0]  rd_sym4;
  int n_err = 0, n_chk = 0;
  logic [31:0] s, e;
  always #5 clk = ~clk;
  rng_seq_register dut (
    .clk(clk), .reset(reset), .start_game(start_game), .rng_in(rng_in), .append(append),
    .rd_req(rd_req), .rd_idx(rd_idx), .seeded(seeded), .seq_len(seq_len), .seq_full(seq_full),
    .rd_valid(rd_valid), .rd_sym(rd_sym), .rd_err(rd_err)
  );
  rng_seq_register #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .start_game(start_game), .rng_in(rng_in), .append(append),
    .rd_req(rd_req), .rd_idx(rd_idx[1:0]), .seeded(seeded4), .seq_len(seq_len4), .seq_full(seq_full4),
    .rd_valid(rd_valid4), .rd_sym(rd_sym4), .rd_err(rd_err4)
  );
  function automatic logic [31:0] lnext(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1; start_game = 0; append = 0; rd_req = 0; rd_idx = 0; rng_in = 0;
    #2 reset = 0;
    #1;
    chk("rst_lfsr", dut.lfsr_q, 32'h1);
    chk("rst_len", seq_len, 0);
    chk("rst_seeded", seeded, 0);
    chk("rst_full", seq_full, 0);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_sym", rd_sym, 0);
    chk("rst_err", rd_err, 0);
    cyc(); cyc();
    reset = 1;
    append = 1; rd_req = 1; rd_idx = 0;
    cyc();
    chk("empty_app_len", seq_len, 0);
    chk("empty_app_lfsr", dut.lfsr_q, 32'h1);
    chk("empty_rd_v", rd_valid, 1);
    chk("empty_rd_err", rd_err, 1);
    chk("empty_rd_sym", rd_sym, 0);
    append = 0; rd_req = 0;
    start_game = 1; rng_in = 0;
    cyc();
    chk("seed0_seeded", seeded, 1);
    chk("seed0_lfsr", dut.lfsr_q, 32'h1);
    chk("seed0_len", seq_len, 0);
    append = 1;
    cyc();
    chk("app1_lfsr", dut.lfsr_q, 32'h8020_0003);
    chk("app1_len", seq_len, 1);
    cyc();
    chk("app2_lfsr", dut.lfsr_q, 32'hC030_0002);
    chk("app2_len", seq_len, 2);
    append = 0;
    rd_req = 1; rd_idx = 0;
    cyc();
    chk("rd0_v", rd_valid, 1);
    chk("rd0_sym", rd_sym, 3);
    chk("rd0_err", rd_err, 0);
    rd_idx = 1;
    cyc();
    chk("rd1_sym", rd_sym, 2);
    chk("rd1_err", rd_err, 0);
    rd_req = 0;
    cyc();
    chk("idle_v", rd_valid, 0);
    chk("idle_sym_hold", rd_sym, 2);
    chk("idle_err_hold", rd_err, 0);
    rd_req = 1; rd_idx = 5;
    cyc();
    chk("oob_v", rd_valid, 1);
    chk("oob_err", rd_err, 1);
    chk("oob_sym", rd_sym, 0);
    rd_idx = 2; append = 1;
    cyc();
    chk("rdapp_err", rd_err, 1);
    chk("rdapp_len", seq_len, 3);
    chk("rdapp_lfsr", dut.lfsr_q, 32'h6018_0001);
    append = 0;
    cyc();
    chk("rd2_sym", rd_sym, 1);
    chk("rd2_err", rd_err, 0);
    rd_req = 0; start_game = 0;
    cyc();
    start_game = 1; append = 1; rng_in = 32'hDEAD_BEEF;
    cyc();
    chk("coinc_len", seq_len, 0);
    chk("coinc_lfsr", dut.lfsr_q, 32'hDEAD_BEEF);
    chk("coinc_len4", seq_len4, 0);
    append = 0; rd_req = 1; rd_idx = 0;
    cyc();
    chk("coinc_nowrite", rd_err, 1);
    rd_req = 0; append = 1;
    e = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i < 4) e = lnext(e);
      chk("d4_len", seq_len4, (i < 4) ? i + 1 : 4);
      chk("d4_full", seq_full4, (i >= 3) ? 1 : 0);
      chk("d4_lfsr", dut4.lfsr_q, e);
    end
    append = 0;
    for (int r = 0; r < 2; r++) begin
      start_game = 0;
      cyc();
      rng_in = 32'h1234_5678; start_game = 1;
      cyc();
      start_game = 0; append = 1;
      for (int i = 0; i < 8; i++) begin
        rng_in = $urandom;
        cyc();
      end
      append = 0;
      chk("rep_len", seq_len, 8);
      s = 32'h1234_5678;
      for (int i = 0; i < 8; i++) begin
        s = lnext(s);
        rd_req = 1; rd_idx = 5'(i);
        cyc();
        chk("rep_sym", rd_sym, {30'd0, s[1:0]});
      end
      rd_req = 0;
    end
    start_game = 0;
    cyc();
    start_game = 1; rng_in = 5;
    cyc();
    append = 1;
    repeat (7) cyc();
    append = 0;
    chk("mid_len", seq_len, 7);
    rd_req = 1; rd_idx = 3;
    #2 reset = 0;
    #1;
    chk("mid_rst_len", seq_len, 0);
    chk("mid_rst_seeded", seeded, 0);
    chk("mid_rst_lfsr", dut.lfsr_q, 32'h1);
    chk("mid_rst_rdv", rd_valid, 0);
    chk("mid_rst_sym", rd_sym, 0);
    chk("mid_rst_err", rd_err, 0);
    rd_req = 0; start_game = 0;
    cyc();
    reset = 1;
    cyc();
    chk("post_rst_rdv", rd_valid, 0);
    append = 1;
    cyc();
    chk("post_rst_rdv2", rd_valid, 0);
    chk("post_rst_app_len", seq_len, 0);
    chk("post_rst_seeded", seeded, 0);
    append = 0; start_game = 1; rng_in = 0;
    cyc();
    append = 1;
    cyc();
    append = 0;
    chk("restart_len", seq_len, 1);
    chk("restart_lfsr", dut.lfsr_q, 32'h8020_0003);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
